// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract that drives an external 4-bit ripple adder one nibble per cycle.
// Optional `define ADDSUB_SAT_EN saturates sum_o on signed overflow.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic [3:0]       rca_a_o,
  output logic [3:0]       rca_b_o,
  output logic             rca_cin_o,
  input  logic [3:0]       rca_s_i,
  input  logic             rca_cout_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             accept;
  logic             ovf_nx;

  assign last   = (idx == IDX_W'(NIBBLES - 1));
  assign accept = start_i && (state != RUN);
  assign ovf_nx = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (rca_s_i[3] != a_reg[WIDTH-1]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_i) state_nx = RUN;
      RUN:        if (last)    state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_o   = 1'b1;
    rca_a_o   = '0;
    rca_b_o   = '0;
    rca_cin_o = 1'b0;
    if (state == RUN) begin
      ready_o   = 1'b0;
      rca_a_o   = a_reg[{idx, 2'b00} +: 4];
      rca_b_o   = b_reg[{idx, 2'b00} +: 4];
      rca_cin_o = carry_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_o     <= '0;
      cout_o    <= 1'b0;
      ovf_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        a_reg     <= a_i;
        b_reg     <= sub_i ? ~b_i : b_i;
        carry_reg <= sub_i;
        idx       <= '0;
        sum_o     <= '0;
        cout_o    <= 1'b0;
        ovf_o     <= 1'b0;
      end else if (state == RUN) begin
        sum_o[{idx, 2'b00} +: 4] <= rca_s_i;
        carry_reg                <= rca_cout_i;
        idx                      <= idx + 1'b1;
        if (last) begin
          cout_o <= rca_cout_i;
          ovf_o  <= ovf_nx;
          done_o <= 1'b1;
          idx    <= '0;
`ifdef ADDSUB_SAT_EN
          // Whole-word write overrides the final nibble write above.
          if (ovf_nx)
            sum_o <= a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub; models the external 4-bit adder and
// compares against a word-level arithmetic reference (honours ADDSUB_SAT_EN).
module tb_nibble_serial_addsub;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_i, start_i, sub_i;
  logic [WIDTH-1:0] a_i, b_i;
  logic             ready_o;
  logic [3:0]       rca_a_o, rca_b_o, rca_s_i;
  logic             rca_cin_o, rca_cout_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o, ovf_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sub_i(sub_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o),
    .rca_a_o(rca_a_o), .rca_b_o(rca_b_o), .rca_cin_o(rca_cin_o),
    .rca_s_i(rca_s_i), .rca_cout_i(rca_cout_i),
    .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o), .done_o(done_o)
  );

  // External combinational 4-bit adder.
  assign {rca_cout_i, rca_s_i} = {1'b0, rca_a_o} + {1'b0, rca_b_o} + {4'b0, rca_cin_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned eff_b(input longint unsigned b, input bit sub);
    return sub ? ((~b) & ((64'd1 << WIDTH) - 1)) : b;
  endfunction

  // Carry entering nibble k = carry out of the low 4k bits of a + b' + sub.
  function automatic bit ref_cin(input longint unsigned a, input longint unsigned b, input bit sub, input int k);
    longint unsigned m, t;
    m = (64'd1 << (4 * k)) - 1;
    t = (a & m) + (eff_b(b, sub) & m) + sub;
    return bit'((t >> (4 * k)) & 1);
  endfunction

  task automatic ref_result(input longint unsigned a, input longint unsigned b, input bit sub,
                            output longint unsigned sum, output bit cout, output bit ovf);
    longint unsigned full, mask;
    bit sa, sb, sr;
    mask = (64'd1 << WIDTH) - 1;
    full = a + eff_b(b, sub) + sub;
    sum  = full & mask;
    cout = bit'((full >> WIDTH) & 1);
    sa = bit'((a >> (WIDTH - 1)) & 1);
    sb = bit'((b >> (WIDTH - 1)) & 1);
    sr = bit'((sum >> (WIDTH - 1)) & 1);
    ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`ifdef ADDSUB_SAT_EN
    if (ovf) sum = sa ? (64'd1 << (WIDTH - 1)) : ((64'd1 << (WIDTH - 1)) - 1);
`endif
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_sum"}, sum_o, 0);
    check({tag, "_cout"}, cout_o, 0);
    check({tag, "_ovf"}, ovf_o, 0);
    check({tag, "_rca"}, {rca_a_o, rca_b_o, rca_cin_o}, 0);
  endtask

  // One operation; disturb pulses start with new operands during RUN,
  // abort_at >= 0 asserts reset in that RUN cycle instead of completing.
  task automatic run_op(input longint unsigned a, input longint unsigned b, input bit sub,
                        input bit disturb, input int abort_at);
    longint unsigned es;
    bit ec, eo;
    ref_result(a, b, sub, es, ec, eo);
    @(negedge clk);
    a_i = WIDTH'(a); b_i = WIDTH'(b); sub_i = sub; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      check("run_ready", ready_o, 0);
      check("run_done", done_o, 0);
      check("rca_a", rca_a_o, (a >> (4 * k)) & 4'hF);
      check("rca_b", rca_b_o, (eff_b(b, sub) >> (4 * k)) & 4'hF);
      check("rca_cin", rca_cin_o, ref_cin(a, b, sub, k));
      if (k == abort_at) begin
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_idle_zero("abort");
        @(negedge clk);
        check("abort_no_done", done_o, 0);
        return;
      end
      if (disturb && k == 1) begin
        a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); sub_i = 1'($urandom); start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check("done_pulse", done_o, 1);
    check("done_ready", ready_o, 1);
    check("sum", sum_o, es);
    check("cout", cout_o, ec);
    check("ovf", ovf_o, eo);
    check("idle_rca", {rca_a_o, rca_b_o, rca_cin_o}, 0);
    @(negedge clk);
    check("done_clear", done_o, 0);
    check("sum_held", sum_o, es);
    check("ovf_held", ovf_o, eo);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; sub_i = 1'($urandom);
    a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    run_op(64'h1234, 64'h0FCD, 1'b0, 1'b0, -1);
    run_op(64'hFFFF, 64'h0001, 1'b0, 1'b0, -1);
    run_op(64'h0005, 64'h0007, 1'b1, 1'b0, -1);
    run_op(64'h7FFF, 64'h0001, 1'b0, 1'b0, -1);
    run_op(64'h8000, 64'h0001, 1'b1, 1'b0, -1);
    run_op(64'h8000, 64'h8000, 1'b0, 1'b0, -1);
    run_op(64'h0000, 64'h0000, 1'b1, 1'b0, -1);
    run_op(64'hABCD, 64'h1111, 1'b0, 1'b1, -1);
    run_op(64'h4321, 64'h9876, 1'b1, 1'b0, 1);
    run_op(64'h0F0F, 64'hF0F1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 40; i++)
      run_op(longint'($urandom_range(16'hFFFF, 0)), longint'($urandom_range(16'hFFFF, 0)),
             1'($urandom), 1'($urandom_range(3, 0) == 0), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
